// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - load/store funct3 codes and data memory FSM states
package riscv_pkg;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane enables, store replication, load extraction and access checks
module mem_lane_align
  import riscv_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic        we,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] raw,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext,
  output logic        err
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    sel_byte   = raw[{addr_lo, 3'b000} +: 8];
    sel_half   = addr_lo[1] ? raw[31:16] : raw[15:0];
    be         = '0;
    wdata_lane = '0;
    rdata_ext  = '0;
    err        = 1'b0;
    case (funct3)
      LS_B, LS_BU: begin
        be         = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = (funct3 == LS_B) ? {{24{sel_byte[7]}}, sel_byte} : {24'h0, sel_byte};
        err        = we && (funct3 == LS_BU);
      end
      LS_H, LS_HU: begin
        be         = 4'b0011 << addr_lo;
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = (funct3 == LS_H) ? {{16{sel_half[15]}}, sel_half} : {16'h0, sel_half};
        err        = addr_lo[0] || (we && (funct3 == LS_HU));
      end
      LS_W: begin
        be         = 4'b1111;
        wdata_lane = wdata;
        rdata_ext  = raw;
        err        = (addr_lo != 2'b00);
      end
      default: err = 1'b1;
    endcase
    // Loads never write; stores and faulting accesses return zero.
    if (err || !we) be = '0;
    if (err || we) rdata_ext = '0;
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - RV32 MEM-stage data memory with valid/ready request and wait states
module data_mem_ctrl
  import riscv_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int DEPTH = 2 ** (ADDR_W - 2);
  localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt;
  logic              we_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic              accept, commit;
  logic              acc_we;
  logic [2:0]        acc_funct3;
  logic [ADDR_W-1:0] acc_addr;
  logic [31:0]       acc_wdata;
  logic [ADDR_W-3:0] word_idx;
  logic [3:0]        be;
  logic [31:0]       wdata_lane, rdata_ext;
  logic              err;

  logic [31:0] mem [DEPTH] = '{default: '0};

  assign req_ready = (state == ST_IDLE) || (state == ST_RESP);
  assign accept    = req_valid && req_ready;
  assign commit    = (WAIT_CYCLES == 0) ? accept : ((state == ST_WAIT) && (cnt == CNT_LAST));

  // A commit on the accept edge only happens with no wait states, so it uses the live request.
  assign acc_we     = accept ? req_we     : we_q;
  assign acc_funct3 = accept ? req_funct3 : funct3_q;
  assign acc_addr   = accept ? req_addr   : addr_q;
  assign acc_wdata  = accept ? req_wdata  : wdata_q;
  assign word_idx   = acc_addr[ADDR_W-1:2];

  mem_lane_align u_align (
    .funct3     (acc_funct3),
    .we         (acc_we),
    .addr_lo    (acc_addr[1:0]),
    .wdata      (acc_wdata),
    .raw        (mem[word_idx]),
    .be         (be),
    .wdata_lane (wdata_lane),
    .rdata_ext  (rdata_ext),
    .err        (err)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_RESP: begin
        if (accept) state_next = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
        else        state_next = ST_IDLE;
      end
      ST_WAIT: if (cnt == CNT_LAST) state_next = ST_RESP;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clear) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      we_q      <= 1'b0;
      funct3_q  <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_next;
      rsp_valid <= commit;
      if (accept) begin
        cnt      <= '0;
        we_q     <= req_we;
        funct3_q <= req_funct3;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
      end else if (state == ST_WAIT) begin
        cnt <= cnt + 1'b1;
      end
      if (commit) begin
        rsp_rdata <= rdata_ext;
        rsp_err   <= err;
      end
    end
  end

  // Array has no reset; a clear on the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (clear && commit) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[word_idx][8*b +: 8] <= wdata_lane[8*b +: 8];
      end
    end
  end

endmodule
